// File: rtl/frame_pkg.sv
// Frame geometry, memory sizing and read-tag types shared by the frame memory arbiter.
package frame_pkg;
  localparam int FRAME_W = 320;
  localparam int FRAME_H = 240;
  localparam int BLK     = 4;
  localparam int NBLOCKS = (FRAME_W / BLK) * (FRAME_H / BLK);
  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 128;

  typedef enum logic {
    OWN_V = 1'b0,
    OWN_G = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
  } rd_tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register carrying {valid, owner, err} alongside each read through the memory latency.
module rd_tag_pipe
  import frame_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    GCLK,
  input  logic    RST_N,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_pre,
  output rd_tag_t tag_out
);
  rd_tag_t stage [RD_LAT+1];

  always_ff @(posedge GCLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i <= RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i <= RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  // tag_pre is the entry whose memory data is on mem_rdata this cycle.
  assign tag_pre = stage[RD_LAT-1];
  assign tag_out = stage[RD_LAT];
endmodule

// File: rtl/frame_mem_arbiter.sv
// Shares the frameMem read port between VGA scanout (V, priority) and game logic (G, best effort)
// with a wait counter that forces a G grant after MAX_WAIT lost cycles.
module frame_mem_arbiter
  import frame_pkg::*;
#(
  parameter int ADDR_W   = frame_pkg::ADDR_W,
  parameter int NBLOCKS  = frame_pkg::NBLOCKS,
  parameter int DATA_W   = frame_pkg::DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              GCLK,
  input  logic              RST_N,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  output logic              v_gnt,
  output logic              v_rvalid,
  output logic [DATA_W-1:0] v_rdata,
  input  logic              g_req,
  input  logic [ADDR_W-1:0] g_addr,
  output logic              g_gnt,
  output logic              g_rvalid,
  output logic [DATA_W-1:0] g_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              addr_err,
  output logic              g_starved
);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(NBLOCKS);
  localparam logic [7:0]      WAIT_MAX   = 8'(MAX_WAIT);

  logic              run_q;
  logic [7:0]        wait_cnt;
  logic              any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_err;
  rd_tag_t           tag_in;
  rd_tag_t           tag_pre;
  rd_tag_t           tag_out;

  // Grants stay off until the first clock edge after reset release.
  always_ff @(posedge GCLK or negedge RST_N) begin
    if (!RST_N) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign g_starved = (wait_cnt == WAIT_MAX);

  always_comb begin
    v_gnt = 1'b0;
    g_gnt = 1'b0;
    if (run_q) begin
      if (g_starved && g_req) g_gnt = 1'b1;
      else if (v_req)         v_gnt = 1'b1;
      else if (g_req)         g_gnt = 1'b1;
    end
  end

  assign any_gnt  = v_gnt | g_gnt;
  assign sel_addr = g_gnt ? g_addr : v_addr;
  assign sel_err  = ({1'b0, sel_addr} >= ADDR_LIMIT);

  always_comb begin
    tag_in       = '0;
    tag_in.valid = any_gnt;
    tag_in.owner = g_gnt ? OWN_G : OWN_V;
    tag_in.err   = any_gnt & sel_err;
  end

  always_ff @(posedge GCLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_addr <= '0;
      addr_err <= 1'b0;
      wait_cnt <= '0;
    end else begin
      addr_err <= any_gnt & sel_err;
      if (any_gnt) mem_addr <= sel_err ? '0 : sel_addr;
      if (!run_q || !g_req || g_gnt) wait_cnt <= '0;
      else if (!g_starved)           wait_cnt <= wait_cnt + 8'd1;
    end
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .GCLK    (GCLK),
    .RST_N   (RST_N),
    .tag_in  (tag_in),
    .tag_pre (tag_pre),
    .tag_out (tag_out)
  );

  assign v_rvalid = tag_out.valid && (tag_out.owner == OWN_V);
  assign g_rvalid = tag_out.valid && (tag_out.owner == OWN_G);

  // Data is captured on the same edge that advances the tag to the output stage.
  always_ff @(posedge GCLK or negedge RST_N) begin
    if (!RST_N) begin
      v_rdata <= '0;
      g_rdata <= '0;
    end else if (tag_pre.valid) begin
      if (tag_pre.owner == OWN_V) v_rdata <= tag_pre.err ? '0 : mem_rdata;
      else                        g_rdata <= tag_pre.err ? '0 : mem_rdata;
    end
  end
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Randomized bench for frame_mem_arbiter against a cycle-scheduled scoreboard and a frameMem model.
module tb_frame_mem_arbiter;
  localparam int RD_LAT   = 3;
  localparam int MAX_WAIT = 8;
  localparam int NBLK     = 4800;

  logic         GCLK = 1'b0;
  logic         RST_N;
  logic         v_req, g_req;
  logic [12:0]  v_addr, g_addr;
  logic         v_gnt, g_gnt, v_rvalid, g_rvalid, addr_err, g_starved;
  logic [127:0] v_rdata, g_rdata, mem_rdata;
  logic [12:0]  mem_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lost = 0;

  bit           ret_v [16];
  bit           ret_g [16];
  logic [127:0] ret_d [16];
  logic [127:0] exp_vd, exp_gd;
  logic [12:0]  exp_ma;
  bit           exp_err;

  frame_mem_arbiter #(
    .RD_LAT   (RD_LAT),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .GCLK      (GCLK),
    .RST_N     (RST_N),
    .v_req     (v_req),
    .v_addr    (v_addr),
    .v_gnt     (v_gnt),
    .v_rvalid  (v_rvalid),
    .v_rdata   (v_rdata),
    .g_req     (g_req),
    .g_addr    (g_addr),
    .g_gnt     (g_gnt),
    .g_rvalid  (g_rvalid),
    .g_rdata   (g_rdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .addr_err  (addr_err),
    .g_starved (g_starved)
  );

  always #5 GCLK = ~GCLK;

  function automatic logic [127:0] blockdata(input logic [12:0] a);
    logic [31:0] x;
    x = {19'h0, a};
    return {x * 32'h9E3779B1, x ^ 32'hA5A5_0000, ~x, x * 32'd40503 + 32'd7};
  endfunction

  // frameMem: data for mem_addr appears RD_LAT-1 cycles after the address is presented.
  logic [12:0] hist [RD_LAT-1];
  always @(posedge GCLK) begin
    hist[0] <= mem_addr;
    for (int i = 1; i < RD_LAT - 1; i++) hist[i] <= hist[i-1];
  end
  assign mem_rdata = blockdata(hist[RD_LAT-2]);

  function automatic logic [12:0] rand_addr();
    return 13'($urandom_range(0, NBLK - 1));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      ret_v[i] = 1'b0;
      ret_g[i] = 1'b0;
      ret_d[i] = '0;
    end
    exp_vd  = '0;
    exp_gd  = '0;
    exp_ma  = '0;
    exp_err = 1'b0;
    lost    = 0;
  endtask

  // One clock of stimulus; scoreboard predicts grants, issue and returns by absolute cycle.
  task automatic drive_cycle(input bit vr, input logic [12:0] va, input bit gr, input logic [12:0] ga);
    bit ev, eg, e_vrv, e_grv, bad, e_st;
    logic [12:0] a;
    int slot;
    @(negedge GCLK);
    v_req = vr; v_addr = va; g_req = gr; g_addr = ga;
    #1;
    e_st = (lost == MAX_WAIT);
    eg = gr && e_st;
    ev = vr && !eg;
    eg = eg || (gr && !vr);
    slot = cyc % 16;
    e_vrv = ret_v[slot] && !ret_g[slot];
    e_grv = ret_v[slot] && ret_g[slot];
    if (e_vrv) exp_vd = ret_d[slot];
    if (e_grv) exp_gd = ret_d[slot];
    ret_v[slot] = 1'b0;
    checks++; if (v_gnt !== ev) begin failures++; $display("FAIL v_gnt cyc=%0d got=%b exp=%b", cyc, v_gnt, ev); end
    checks++; if (g_gnt !== eg) begin failures++; $display("FAIL g_gnt cyc=%0d got=%b exp=%b", cyc, g_gnt, eg); end
    checks++; if (g_starved !== e_st) begin failures++; $display("FAIL g_starved cyc=%0d got=%b exp=%b", cyc, g_starved, e_st); end
    checks++; if (v_rvalid !== e_vrv) begin failures++; $display("FAIL v_rvalid cyc=%0d got=%b exp=%b", cyc, v_rvalid, e_vrv); end
    checks++; if (g_rvalid !== e_grv) begin failures++; $display("FAIL g_rvalid cyc=%0d got=%b exp=%b", cyc, g_rvalid, e_grv); end
    checks++; if (v_rdata !== exp_vd) begin failures++; $display("FAIL v_rdata cyc=%0d got=%h exp=%h", cyc, v_rdata, exp_vd); end
    checks++; if (g_rdata !== exp_gd) begin failures++; $display("FAIL g_rdata cyc=%0d got=%h exp=%h", cyc, g_rdata, exp_gd); end
    checks++; if (mem_addr !== exp_ma) begin failures++; $display("FAIL mem_addr cyc=%0d got=%0d exp=%0d", cyc, mem_addr, exp_ma); end
    checks++; if (addr_err !== exp_err) begin failures++; $display("FAIL addr_err cyc=%0d got=%b exp=%b", cyc, addr_err, exp_err); end
    exp_err = 1'b0;
    if (ev || eg) begin
      a = ev ? va : ga;
      bad = (int'(a) >= NBLK);
      if (!bad) exp_ma = a;
      else      exp_ma = '0;
      exp_err = bad;
      slot = (cyc + 1 + RD_LAT) % 16;
      ret_v[slot] = 1'b1;
      ret_g[slot] = eg;
      ret_d[slot] = bad ? '0 : blockdata(a);
    end
    if (!gr || eg) lost = 0;
    else if (lost < MAX_WAIT) lost++;
    cyc++;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    v_req = 1'b1; g_req = 1'b1; v_addr = 13'd17; g_addr = 13'd4900;
    repeat (3) begin
      @(negedge GCLK); #1;
      checks++;
      if ({v_gnt, g_gnt, v_rvalid, g_rvalid, addr_err, g_starved} !== 6'b0) begin
        failures++;
        $display("FAIL reset_ctl got=%b exp=000000", {v_gnt, g_gnt, v_rvalid, g_rvalid, addr_err, g_starved});
      end
      checks++;
      if (mem_addr !== 13'd0) begin failures++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
      checks++;
      if ((v_rdata | g_rdata) !== 128'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", v_rdata | g_rdata); end
    end
    @(negedge GCLK);
    g_req = 1'b0;
    RST_N = 1'b1;
    #1;
    checks++;
    if (v_gnt !== 1'b0) begin failures++; $display("FAIL release_cycle_gnt got=%b exp=0", v_gnt); end
    model_reset();
    drive_cycle(1'b1, 13'd5, 1'b0, 13'd0);
    checks++;
    if (v_gnt !== 1'b1) begin failures++; $display("FAIL first_gnt got=%b exp=1", v_gnt); end
    repeat (RD_LAT + 2) drive_cycle(1'b0, 13'd0, 1'b0, 13'd0);
  endtask

  task automatic test_v_only();
    int ngnt = 0, nrv = 0;
    for (int a = 0; a < NBLK; a++) begin
      drive_cycle(1'b1, 13'(a), 1'b0, 13'd0);
      ngnt += int'(v_gnt);
      nrv  += int'(v_rvalid);
    end
    repeat (RD_LAT + 2) begin
      drive_cycle(1'b0, 13'd0, 1'b0, 13'd0);
      nrv += int'(v_rvalid);
    end
    checks++; if (ngnt != NBLK) begin failures++; $display("FAIL v_only_gnts got=%0d exp=%0d", ngnt, NBLK); end
    checks++; if (nrv != NBLK) begin failures++; $display("FAIL v_only_rvalids got=%0d exp=%0d", nrv, NBLK); end
  endtask

  task automatic test_starvation();
    int ng = 0, ns = 0;
    repeat (2) drive_cycle(1'b0, 13'd0, 1'b0, 13'd0);
    for (int k = 0; k < 36; k++) begin
      drive_cycle(1'b1, rand_addr(), 1'b1, rand_addr());
      ns += int'(g_starved);
      if (g_gnt) begin
        ng++;
        checks++;
        if (k % 9 != 8) begin failures++; $display("FAIL starve_pos got=%0d exp=%0d", k % 9, 8); end
      end
    end
    checks++; if (ng != 4) begin failures++; $display("FAIL starve_g_gnts got=%0d exp=4", ng); end
    checks++; if (ns != 4) begin failures++; $display("FAIL starve_level_cycles got=%0d exp=4", ns); end
    repeat (RD_LAT + 2) drive_cycle(1'b0, 13'd0, 1'b0, 13'd0);
  endtask

  task automatic test_addr_err();
    logic [12:0] addrs [4];
    bit bad;
    addrs[0] = 13'd4799; addrs[1] = 13'd4800; addrs[2] = 13'd4799; addrs[3] = 13'd8191;
    for (int k = 0; k < 4; k++) begin
      bad = (int'(addrs[k]) >= NBLK);
      drive_cycle(1'b0, 13'd0, 1'b1, addrs[k]);
      checks++; if (g_gnt !== 1'b1) begin failures++; $display("FAIL oor_gnt addr=%0d got=%b exp=1", addrs[k], g_gnt); end
      drive_cycle(1'b0, 13'd0, 1'b0, 13'd0);
      checks++; if (addr_err !== bad) begin failures++; $display("FAIL oor_err addr=%0d got=%b exp=%b", addrs[k], addr_err, bad); end
      checks++; if (mem_addr !== (bad ? 13'd0 : addrs[k])) begin failures++; $display("FAIL oor_mem_addr addr=%0d got=%0d", addrs[k], mem_addr); end
      repeat (RD_LAT - 1) drive_cycle(1'b0, 13'd0, 1'b0, 13'd0);
      drive_cycle(1'b0, 13'd0, 1'b0, 13'd0);
      checks++; if (g_rvalid !== 1'b1) begin failures++; $display("FAIL oor_rvalid addr=%0d got=%b exp=1", addrs[k], g_rvalid); end
      checks++; if (g_rdata !== (bad ? 128'd0 : blockdata(addrs[k]))) begin failures++; $display("FAIL oor_rdata addr=%0d got=%h", addrs[k], g_rdata); end
    end
  endtask

  task automatic test_alternate();
    int nv = 0, ng = 0;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) drive_cycle(1'b1, rand_addr(), 1'b0, 13'd0);
      else            drive_cycle(1'b0, 13'd0, 1'b1, rand_addr());
      nv += int'(v_rvalid);
      ng += int'(g_rvalid);
    end
    repeat (RD_LAT + 2) begin
      drive_cycle(1'b0, 13'd0, 1'b0, 13'd0);
      nv += int'(v_rvalid);
      ng += int'(g_rvalid);
    end
    checks++; if (nv != 20) begin failures++; $display("FAIL alt_v_returns got=%0d exp=20", nv); end
    checks++; if (ng != 20) begin failures++; $display("FAIL alt_g_returns got=%0d exp=20", ng); end
  endtask

  task automatic test_random();
    logic [12:0] va, ga;
    for (int k = 0; k < 400; k++) begin
      va = ($urandom_range(0, 15) == 0) ? 13'($urandom_range(NBLK, 8191)) : rand_addr();
      ga = ($urandom_range(0, 15) == 0) ? 13'($urandom_range(NBLK, 8191)) : rand_addr();
      drive_cycle($urandom_range(0, 9) < 6, va, $urandom_range(0, 1) == 1, ga);
      checks++;
      if ((v_gnt & g_gnt) !== 1'b0) begin failures++; $display("FAIL one_hot_gnt cyc=%0d got=%b%b", cyc, v_gnt, g_gnt); end
    end
    repeat (RD_LAT + 2) drive_cycle(1'b0, 13'd0, 1'b0, 13'd0);
  endtask

  task automatic test_reset_midflight();
    int nrv = 0;
    repeat (3) drive_cycle(1'b1, rand_addr(), 1'b1, rand_addr());
    v_req = 1'b0; g_req = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({v_rvalid, g_rvalid, addr_err, g_starved, v_gnt, g_gnt} !== 6'b0) begin
      failures++;
      $display("FAIL midflight_ctl got=%b exp=000000", {v_rvalid, g_rvalid, addr_err, g_starved, v_gnt, g_gnt});
    end
    checks++;
    if (mem_addr !== 13'd0 || v_rdata !== 128'd0) begin failures++; $display("FAIL midflight_regs mem_addr=%0d v_rdata=%h exp=0", mem_addr, v_rdata); end
    repeat (3) @(negedge GCLK);
    RST_N = 1'b1;
    model_reset();
    repeat (RD_LAT + 3) begin
      drive_cycle(1'b0, 13'd0, 1'b0, 13'd0);
      nrv += int'(v_rvalid) + int'(g_rvalid);
    end
    checks++; if (nrv != 0) begin failures++; $display("FAIL stale_returns got=%0d exp=0", nrv); end
    repeat (10) drive_cycle(1'b1, rand_addr(), 1'b1, rand_addr());
    repeat (RD_LAT + 2) drive_cycle(1'b0, 13'd0, 1'b0, 13'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    v_req = 1'b0; g_req = 1'b0; v_addr = '0; g_addr = '0;
    model_reset();
    test_reset();
    test_v_only();
    test_starvation();
    test_addr_err();
    test_alternate();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
